pixel_stream_reducer: RTL and testbench

- Streaming write-side pixel format converter: takes expanded pixels (CONV_SUB_PIXEL_WIDTH per sub pixel) from the fragment/blend path and reduces them to the framebuffer storage format (SUB_PIXEL_WIDTH per sub pixel).
- Optional 4x4 ordered (Bayer) dithering, rounding with saturation.
- Packs PIXEL_PER_BEAT reduced pixels into one memory-bus beat; the inverse of the framebuffer read/expand path.

---
 rtl/pixel_stream_reducer_pkg.sv | 41 ++++
 rtl/pixel_stream_reducer_dither_reduce.sv | 34 +++
 rtl/pixel_stream_reducer.sv | 157 +++++++++++++++
 tb/tb_pixel_stream_reducer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_reducer_pkg.sv
// Shared width derivations, the 4x4 ordered-dither matrix and the
// saturating sub pixel reduce used by the write-side pixel reducer.
package pixel_stream_reducer_pkg;

  // Ordered (Bayer) matrix, indexed [y][x].
  localparam logic [3:0] BAYER [0:3][0:3] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  function automatic int pixel_width(input int sub_width, input int sub_count);
    return sub_width * sub_count;
  endfunction

  function automatic int diff_sub_pixel_width(input int conv_width, input int sub_width);
    return conv_width - sub_width;
  endfunction

  // Threshold scaled to the number of bits being dropped; zero when nothing is dropped.
  function automatic logic [3:0] bayer_threshold(input logic [1:0] x, input logic [1:0] y,
                                                 input int diff);
    logic [3:0] b;
    b = BAYER[y][x];
    if (diff <= 0) return 4'd0;
    return b >> (4 - diff);
  endfunction

  // Keeps the top sub_width bits of a conv_width value; a carry out of
  // conv_width bits saturates to all ones. With no threshold added this is
  // plain truncation, so both reduce modes share it.
  function automatic logic [31:0] reduce_sub(input logic [31:0] s, input int conv_width,
                                             input int sub_width);
    logic [31:0] all_ones;
    all_ones = (32'd1 << sub_width) - 32'd1;
    if ((s >> conv_width) != 32'd0) return all_ones;
    return (s >> (conv_width - sub_width)) & all_ones;
  endfunction

endpackage

// File: rtl/pixel_stream_reducer_dither_reduce.sv
// Combinational per-pixel reduce: optional ordered dither threshold added to
// every sub pixel (alpha included), then saturating truncation.
module pixel_dither_reduce
  import pixel_stream_reducer_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH      = 4,
  parameter int CONV_SUB_PIXEL_WIDTH = 8,
  parameter int NUMBER_OF_SUB_PIXELS = 4
) (
  input  logic [CONV_SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] pixel,
  input  logic [1:0]                                           x,
  input  logic [1:0]                                           y,
  input  logic                                                 enable,
  output logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0]      reduced
);

  localparam int DIFF = diff_sub_pixel_width(CONV_SUB_PIXEL_WIDTH, SUB_PIXEL_WIDTH);

  logic [3:0] threshold;
  assign threshold = bayer_threshold(x, y, DIFF);

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_SUB_PIXELS; gi++) begin : g_sub
      logic [31:0] c_ext;
      logic [31:0] s_ext;
      assign c_ext = 32'(pixel[gi*CONV_SUB_PIXEL_WIDTH +: CONV_SUB_PIXEL_WIDTH]);
      assign s_ext = enable ? (c_ext + 32'(threshold)) : c_ext;
      assign reduced[gi*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH] =
        SUB_PIXEL_WIDTH'(reduce_sub(s_ext, CONV_SUB_PIXEL_WIDTH, SUB_PIXEL_WIDTH));
    end
  endgenerate

endmodule

// File: rtl/pixel_stream_reducer.sv
// Write-side pixel reducer: stage 1 reduces (and optionally dithers) each
// accepted pixel, stage 2 packs reduced pixels into memory-bus beats.
module pixel_stream_reducer
  import pixel_stream_reducer_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH      = 4,
  parameter int CONV_SUB_PIXEL_WIDTH = 8,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int PIXEL_PER_BEAT       = 2
) (
  input  logic                                                    aclk,
  input  logic                                                    reset,
  input  logic                                                    cfg_dither_enable,
  input  logic                                                    s_axis_tvalid,
  output logic                                                    s_axis_tready,
  input  logic [CONV_SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0]    s_axis_tdata,
  input  logic                                                    s_axis_tlast,
  input  logic                                                    s_axis_tuser,
  output logic                                                    m_axis_tvalid,
  input  logic                                                    m_axis_tready,
  output logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS*PIXEL_PER_BEAT-1:0] m_axis_tdata,
  output logic [PIXEL_PER_BEAT-1:0]                               m_axis_tkeep,
  output logic                                                    m_axis_tlast
);

  localparam int PIXEL_WIDTH = pixel_width(SUB_PIXEL_WIDTH, NUMBER_OF_SUB_PIXELS);
  localparam int DIFF        = diff_sub_pixel_width(CONV_SUB_PIXEL_WIDTH, SUB_PIXEL_WIDTH);
  localparam int BEAT_W      = PIXEL_WIDTH * PIXEL_PER_BEAT;
  localparam int SLOT_W      = (PIXEL_PER_BEAT > 1) ? $clog2(PIXEL_PER_BEAT) : 1;

  generate
    if (DIFF < 0 || DIFF > 4) begin : g_bad_diff
      $error("CONV_SUB_PIXEL_WIDTH - SUB_PIXEL_WIDTH must be 0..4");
    end
    if (PIXEL_PER_BEAT < 1) begin : g_bad_ppb
      $error("PIXEL_PER_BEAT must be at least 1");
    end
  endgenerate

  logic [1:0]             x_reg, y_reg;
  logic                   s1_valid_reg, s1_last_reg, s1_user_reg;
  logic [PIXEL_WIDTH-1:0] s1_data_reg;
  logic [BEAT_W-1:0]      acc_data_reg;
  logic [PIXEL_PER_BEAT-1:0] acc_keep_reg;
  logic [SLOT_W-1:0]      slot_reg;
  logic                   m_valid_reg, m_last_reg;
  logic [BEAT_W-1:0]      m_data_reg;
  logic [PIXEL_PER_BEAT-1:0] m_keep_reg;

  logic [1:0]             in_x, in_y;
  logic [PIXEL_WIDTH-1:0] in_reduced;
  logic                   accept, out_free, flush, flush_fire, closing, s1_consume, beat_load;
  logic [BEAT_W-1:0]      slot_data;
  logic [PIXEL_PER_BEAT-1:0] slot_keep;

  // A frame-start pixel is always dithered at the origin.
  assign in_x = s_axis_tuser ? 2'd0 : x_reg;
  assign in_y = s_axis_tuser ? 2'd0 : y_reg;

  pixel_dither_reduce #(
    .SUB_PIXEL_WIDTH      (SUB_PIXEL_WIDTH),
    .CONV_SUB_PIXEL_WIDTH (CONV_SUB_PIXEL_WIDTH),
    .NUMBER_OF_SUB_PIXELS (NUMBER_OF_SUB_PIXELS)
  ) u_reduce (
    .pixel   (s_axis_tdata),
    .x       (in_x),
    .y       (in_y),
    .enable  (cfg_dither_enable),
    .reduced (in_reduced)
  );

  // A frame-start pixel meeting a half-filled beat first pushes that beat out
  // and stays in stage 1 for one extra cycle, so it lands in slot 0.
  assign out_free   = !m_valid_reg || m_axis_tready;
  assign flush      = s1_valid_reg && s1_user_reg && (acc_keep_reg != '0);
  assign flush_fire = flush && out_free;
  assign closing    = (slot_reg == SLOT_W'(PIXEL_PER_BEAT - 1)) || s1_last_reg;
  assign s1_consume = s1_valid_reg && !flush && (!closing || out_free);
  assign beat_load  = flush_fire || (s1_consume && closing);
  assign slot_data  = BEAT_W'(s1_data_reg) << (int'(slot_reg) * PIXEL_WIDTH);
  assign slot_keep  = PIXEL_PER_BEAT'(1) << slot_reg;

  assign s_axis_tready = !reset && !(s1_valid_reg && !s1_consume);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tkeep  = m_keep_reg;
  assign m_axis_tlast  = m_last_reg;

  // Stage 1 register and dither coordinate tracking.
  always_ff @(posedge aclk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_last_reg  <= 1'b0;
      s1_user_reg  <= 1'b0;
      x_reg        <= 2'd0;
      y_reg        <= 2'd0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_data_reg  <= in_reduced;
      s1_last_reg  <= s_axis_tlast;
      s1_user_reg  <= s_axis_tuser;
      if (s_axis_tlast) begin
        x_reg <= 2'd0;
        y_reg <= in_y + 2'd1;
      end else begin
        x_reg <= in_x + 2'd1;
        y_reg <= in_y;
      end
    end else if (s1_consume) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Partial beat accumulator; cleared whenever its contents leave as a beat.
  always_ff @(posedge aclk) begin
    if (reset) begin
      acc_data_reg <= '0;
      acc_keep_reg <= '0;
      slot_reg     <= '0;
    end else if (flush_fire || (s1_consume && closing)) begin
      acc_data_reg <= '0;
      acc_keep_reg <= '0;
      slot_reg     <= '0;
    end else if (s1_consume) begin
      acc_data_reg <= acc_data_reg | slot_data;
      acc_keep_reg <= acc_keep_reg | slot_keep;
      slot_reg     <= slot_reg + SLOT_W'(1);
    end
  end

  // Output beat register, held stable while the consumer stalls.
  always_ff @(posedge aclk) begin
    if (reset) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_keep_reg  <= '0;
      m_last_reg  <= 1'b0;
    end else if (beat_load) begin
      m_valid_reg <= 1'b1;
      if (flush_fire) begin
        m_data_reg <= acc_data_reg;
        m_keep_reg <= acc_keep_reg;
        m_last_reg <= 1'b0;
      end else begin
        m_data_reg <= acc_data_reg | slot_data;
        m_keep_reg <= acc_keep_reg | slot_keep;
        m_last_reg <= s1_last_reg;
      end
    end else if (m_axis_tready) begin
      m_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_reducer.sv
// Randomised and directed bench for pixel_stream_reducer against a
// behavioural model of reduce, dither coordinates and beat packing.
module tb_pixel_stream_reducer;

  localparam int SUB  = 4;
  localparam int CONV = 8;
  localparam int NSUB = 4;
  localparam int PPB  = 2;
  localparam int PW   = SUB * NSUB;
  localparam int BW   = PW * PPB;
  localparam int DIFF = CONV - SUB;

  logic            aclk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_dither_enable = 1'b0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [CONV*NSUB-1:0] s_axis_tdata = '0;
  logic            s_axis_tlast = 1'b0;
  logic            s_axis_tuser = 1'b0;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic [BW-1:0]   m_axis_tdata;
  logic [PPB-1:0]  m_axis_tkeep;
  logic            m_axis_tlast;

  always #5 aclk = ~aclk;

  pixel_stream_reducer #(
    .SUB_PIXEL_WIDTH(SUB), .CONV_SUB_PIXEL_WIDTH(CONV),
    .NUMBER_OF_SUB_PIXELS(NSUB), .PIXEL_PER_BEAT(PPB)
  ) dut (
    .aclk(aclk), .reset(reset), .cfg_dither_enable(cfg_dither_enable),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast)
  );

  typedef struct {
    logic [BW-1:0]  data;
    logic [PPB-1:0] keep;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int bayer_tb [0:3][0:3] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  int             mx = 0, my = 0, pcount = 0;
  logic [BW-1:0]  pdata = '0;
  logic [PPB-1:0] pkeep = '0;

  function automatic logic [PW-1:0] model_reduce(input logic [CONV*NSUB-1:0] d, input int x,
                                                 input int y, input bit en);
    logic [PW-1:0] res;
    int c, t, s, r;
    res = '0;
    for (int i = 0; i < NSUB; i++) begin
      c = int'((d >> (i * CONV)) & ((1 << CONV) - 1));
      t = en ? (bayer_tb[y][x] >> (4 - DIFF)) : 0;
      s = c + t;
      r = (s >= (1 << CONV)) ? ((1 << SUB) - 1) : (s >> DIFF);
      res = res | (PW'(r) << (i * SUB));
    end
    return res;
  endfunction

  // Monitor: model update on accepted pixels, scoreboard on accepted beats, hold check on stalls.
  initial begin : monitor
    bit             stalled;
    beat_t          held, e;
    logic [PW-1:0]  red;
    int             ux, uy;
    stalled = 1'b0;
    forever begin
      @(negedge aclk);
      if (reset) begin
        exp_q.delete();
        mx = 0; my = 0; pcount = 0; pdata = '0; pkeep = '0;
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_cmp++;
          if (!m_axis_tvalid || m_axis_tdata !== held.data || m_axis_tkeep !== held.keep ||
              m_axis_tlast !== held.last) begin
            n_err++;
            $display("FAIL stall_hold: got v=%0b d=%h k=%b l=%0b, need v=1 d=%h k=%b l=%0b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                     held.data, held.keep, held.last);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got d=%h k=%b l=%0b, need no beat",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last) begin
              n_err++;
              $display("FAIL beat: got d=%h k=%b l=%0b, need d=%h k=%b l=%0b",
                       m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.data, e.keep, e.last);
            end else begin
              $display("beat d=%h k=%b l=%0b ok", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
            end
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held.data = m_axis_tdata; held.keep = m_axis_tkeep; held.last = m_axis_tlast;
        if (s_axis_tvalid && s_axis_tready) begin
          ux = s_axis_tuser ? 0 : mx;
          uy = s_axis_tuser ? 0 : my;
          red = model_reduce(s_axis_tdata, ux, uy, cfg_dither_enable);
          if (s_axis_tuser && pcount > 0) begin
            e.data = pdata; e.keep = pkeep; e.last = 1'b0;
            exp_q.push_back(e);
            pcount = 0; pdata = '0; pkeep = '0;
          end
          pdata = pdata | (BW'(red) << (pcount * PW));
          pkeep = pkeep | (PPB'(1) << pcount);
          pcount++;
          if (pcount == PPB || s_axis_tlast) begin
            e.data = pdata; e.keep = pkeep; e.last = s_axis_tlast;
            exp_q.push_back(e);
            pcount = 0; pdata = '0; pkeep = '0;
          end
          if (s_axis_tlast) begin mx = 0; my = (uy + 1) % 4; end
          else begin mx = (ux + 1) % 4; my = uy; end
        end
      end
    end
  end

  // Presents one pixel (caller at posedge+1) and returns at posedge+1 after it is taken.
  task automatic send(input logic [CONV*NSUB-1:0] d, input logic last, input logic user,
                      input logic en);
    bit ok;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user;
    cfg_dither_enable = en;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got tready=0 for 200 cycles, need acceptance");
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic wait_beat(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b d=%h k=%b l=%0b, need all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_err++; $display("FAIL reset_tready: got %0b, need 0", s_axis_tready);
    end
    @(posedge aclk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_tready: got %0b, need 1", s_axis_tready);
    end
    $display("reset done");
  endtask

  task automatic test_truncate();
    send(32'h12345678, 1'b0, 1'b0, 1'b0);
    send(32'hFFEEDDCC, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL trunc_early: got tvalid=%0b one cycle after accept, need 0", m_axis_tvalid);
    end
    @(posedge aclk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hFEDC1357 || m_axis_tkeep !== 2'b11 ||
        m_axis_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL trunc_beat: got v=%0b d=%h k=%b l=%0b, need v=1 d=fedc1357 k=11 l=0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_dither();
    send(32'h00000000, 1'b0, 1'b1, 1'b1);
    send(32'hF8787878, 1'b0, 1'b0, 1'b1);
    @(posedge aclk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hF8880000 || m_axis_tkeep !== 2'b11) begin
      n_err++;
      $display("FAIL dither_beat: got v=%0b d=%h k=%b, need v=1 d=f8880000 k=11",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_tlast();
    send(32'hAABBCCDD, 1'b1, 1'b0, 1'b0);
    @(posedge aclk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000ABCD || m_axis_tkeep !== 2'b01 ||
        m_axis_tlast !== 1'b1) begin
      n_err++;
      $display("FAIL tlast_beat: got v=%0b d=%h k=%b l=%0b, need v=1 d=0000abcd k=01 l=1",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    send(32'h74747474, 1'b1, 1'b0, 1'b1);
    @(posedge aclk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00008888 || m_axis_tkeep !== 2'b01) begin
      n_err++;
      $display("FAIL next_line_dither: got v=%0b d=%h k=%b, need v=1 d=00008888 k=01",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_tuser_flush();
    bit ok1, ok2;
    logic [BW-1:0] d1, d2;
    logic [PPB-1:0] k1, k2;
    logic l1, l2;
    fork
      begin
        send(32'h11111111, 1'b0, 1'b0, 1'b0);
        send(32'h22222222, 1'b0, 1'b1, 1'b0);
        send(32'h33333333, 1'b1, 1'b0, 1'b0);
      end
      begin
        wait_beat(ok1);
        d1 = m_axis_tdata; k1 = m_axis_tkeep; l1 = m_axis_tlast;
        @(posedge aclk); #1;
        wait_beat(ok2);
        d2 = m_axis_tdata; k2 = m_axis_tkeep; l2 = m_axis_tlast;
      end
    join
    n_cmp++;
    if (!ok1 || d1 !== 32'h00001111 || k1 !== 2'b01 || l1 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_beat: got ok=%0b d=%h k=%b l=%0b, need d=00001111 k=01 l=0", ok1, d1, k1, l1);
    end
    n_cmp++;
    if (!ok2 || d2 !== 32'h33332222 || k2 !== 2'b11 || l2 !== 1'b1) begin
      n_err++;
      $display("FAIL tuser_slot0: got ok=%0b d=%h k=%b l=%0b, need d=33332222 k=11 l=1", ok2, d2, k2, l2);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = $urandom; s_axis_tuser = 1'b0;
      s_axis_tlast = (i == 7); cfg_dither_enable = $urandom_range(0, 1);
      @(negedge aclk);
      n_cmp++;
      if (s_axis_tready !== 1'b1) begin
        n_err++; $display("FAIL back_to_back_tready: pixel %0d got tready=%0b, need 1", i, s_axis_tready);
      end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge aclk); #1;
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
          send($urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
               $urandom_range(0, 1));
        end
        send($urandom, 1'b1, 1'b0, 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          repeat (7) @(posedge aclk); #1;
          m_axis_tready = 1'b0;
          repeat (5) @(posedge aclk); #1;
          m_axis_tready = 1'b1;
        end
      end
    join
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge aclk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL random_drain: got %0d beats outstanding, need 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    m_axis_tready = 1'b0;
    send(32'h11111111, 1'b0, 1'b1, 1'b1);
    send(32'h22222222, 1'b1, 1'b0, 1'b1);
    send(32'h33333333, 1'b0, 1'b0, 1'b1);
    send(32'h44444444, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_err++; $display("FAIL stage1_blocked: got tready=%0b, need 0", s_axis_tready);
    end
    reset = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_reset: got v=%0b d=%h k=%b l=%0b, need all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    send(32'h7E7E7E7E, 1'b1, 1'b0, 1'b1);
    @(posedge aclk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00007777 || m_axis_tkeep !== 2'b01 ||
        m_axis_tlast !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset_origin: got v=%0b d=%h k=%b l=%0b, need v=1 d=00007777 k=01 l=1",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    repeat (2) @(posedge aclk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_truncate();
    test_dither();
    test_tlast();
    test_tuser_flush();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    repeat (4) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
